// File: rtl/serial_add_pkg.sv
// Shared definitions for the serial digit adder.
//   DIGIT_W : bits processed per cycle by the adder slice
//   state_e : controller states IDLE -> RUN -> DONE
package serial_add_pkg;

  localparam int unsigned DIGIT_W = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/add2_cin.sv
// Purely combinational 2-bit adder slice with carry-in.
// Ports:
//   a, b : digit operands (DIGIT_W bits)
//   cin  : carry-in
//   s    : digit sum (DIGIT_W bits)
//   cout : carry-out
import serial_add_pkg::*;

module add2_cin (
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  input  logic               cin,
  output logic [DIGIT_W-1:0] s,
  output logic               cout
);

  always_comb begin
    {cout, s} = {1'b0, a} + {1'b0, b} + {{DIGIT_W{1'b0}}, cin};
  end

endmodule

// File: rtl/serial_add_ctrl.sv
// Serial adder: sequences a single add2_cin slice over the operands, one
// 2-bit digit per cycle, LSB digit first. Result appears with a one-cycle
// done pulse and is held until the next accepted start.
// Optional feature (macro SERIAL_ADD_SUB_EN): adds input 'sub'; when set at
// start, b is complemented and the carry seeded with 1, giving a-b with
// sum[WIDTH]=1 meaning no borrow.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   start : begin an operation (accepted in IDLE or DONE)
//   a, b  : operands (WIDTH bits), sampled on the accepted start cycle
//   sub   : subtract select (only with SERIAL_ADD_SUB_EN)
//   busy  : high while digits are processed
//   done  : one-cycle pulse, sum valid
//   sum   : WIDTH+1 bit result, bit WIDTH is the final carry-out
// WIDTH must be even and at least 4.
import serial_add_pkg::*;

module serial_add_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH:0]   sum
);

  localparam int unsigned NUM_DIGITS = WIDTH / DIGIT_W;
  localparam int unsigned CNT_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_DIGITS - 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               carry_q, carry_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH:0]     sum_q, sum_d;

  logic [DIGIT_W-1:0] digit_a, digit_b, digit_s;
  logic               digit_cout;
  logic               sub_op;

`ifdef SERIAL_ADD_SUB_EN
  assign sub_op = sub;
`else
  assign sub_op = 1'b0;
`endif

  assign digit_a = a_q[DIGIT_W*cnt_q +: DIGIT_W];
  assign digit_b = b_q[DIGIT_W*cnt_q +: DIGIT_W];

  add2_cin u_add2_cin (
    .a    (digit_a),
    .b    (digit_b),
    .cin  (carry_q),
    .s    (digit_s),
    .cout (digit_cout)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;

    unique case (state_q)
      // DONE accepts a new start just like IDLE so operations can run back to back.
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          a_d     = a;
          b_d     = sub_op ? ~b : b;
          carry_d = sub_op;
          cnt_d   = '0;
          sum_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        sum_d[DIGIT_W*cnt_q +: DIGIT_W] = digit_s;
        carry_d = digit_cout;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) begin
          sum_d[WIDTH] = digit_cout;
          state_d      = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign sum  = sum_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl (WIDTH=8). Expected results come
// from plain integer arithmetic; timing expectations from the documented
// latency (4 busy cycles, then one done cycle).
module tb_serial_add_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       sub;
  logic       busy;
  logic       done;
  logic [8:0] sum;

  int checks = 0;
  int errors = 0;

  serial_add_ctrl #(
    .WIDTH (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
`ifdef SERIAL_ADD_SUB_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [8:0] model(input logic [7:0] x, input logic [7:0] y,
                                       input bit do_sub);
    int r;
    if (do_sub) r = (int'(x) + 256 - int'(y)) % 512;
    else        r = int'(x) + int'(y);
    return r[8:0];
  endfunction

  // Called at the first negedge after the accepting edge is due; checks four
  // busy cycles with partial sums, then the done cycle.
  task automatic finish_op(input logic [8:0] exp, input bit noise);
    logic [8:0] mask;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      mask = (9'h1 << (2 * k)) - 9'h1;
      checks++;
      if (busy !== 1'b1) begin
        errors++;
        $display("FAIL run_busy k=%0d: got %b expected 1", k, busy);
      end
      checks++;
      if (done !== 1'b0) begin
        errors++;
        $display("FAIL run_done k=%0d: got %b expected 0", k, done);
      end
      checks++;
      if (sum !== (exp & mask)) begin
        errors++;
        $display("FAIL partial_sum k=%0d: got %h expected %h", k, sum, exp & mask);
      end
      if (noise) begin
        start = 1'($urandom);
        a     = 8'($urandom);
        b     = 8'($urandom);
        sub   = 1'($urandom);
      end else begin
        start = 1'b0;
      end
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL done_pulse: got %b expected 1", done);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL done_busy: got %b expected 0", busy);
    end
    checks++;
    if (sum !== exp) begin
      errors++;
      $display("FAIL result: got %h expected %h", sum, exp);
    end
    start = 1'b0;
  endtask

  task automatic start_op(input logic [7:0] ta, input logic [7:0] tb, input bit ts,
                          input bit noise);
    @(negedge clk);
    start = 1'b1;
    a     = ta;
    b     = tb;
    sub   = ts;
`ifdef SERIAL_ADD_SUB_EN
    finish_op(model(ta, tb, ts), noise);
`else
    finish_op(model(ta, tb, 1'b0), noise);
`endif
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    sub   = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy: got %b expected 0", busy);
    end
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL reset_done: got %b expected 0", done);
    end
    checks++;
    if (sum !== 9'h000) begin
      errors++;
      $display("FAIL reset_sum: got %h expected 000", sum);
    end
    // Release with start already high: first edge after release must accept.
    @(negedge clk);
    rst_n = 1'b1;
    start = 1'b1;
    a     = 8'hFF;
    b     = 8'h01;
    finish_op(9'h100, 1'b0);
  endtask

  task automatic test_hold;
    start_op(8'h5A, 8'hA5, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (sum !== 9'h0FF || busy !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("FAIL hold i=%0d: got sum=%h busy=%b done=%b expected 0ff/0/0",
                 i, sum, busy, done);
      end
    end
  endtask

  task automatic test_back_to_back;
    bit exp_done;
    @(negedge clk);
    start = 1'b1;
    a     = 8'h03;
    b     = 8'h01;
    sub   = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      exp_done = (i == 4) || (i == 9);
      checks++;
      if (done !== exp_done || busy !== !exp_done) begin
        errors++;
        $display("FAIL b2b_timing i=%0d: got done=%b busy=%b expected done=%b",
                 i, done, busy, exp_done);
      end
      if (i == 4) begin
        checks++;
        if (sum !== 9'h004) begin
          errors++;
          $display("FAIL b2b_first: got %h expected 004", sum);
        end
        a = 8'h80;
        b = 8'h80;
      end
      if (i == 9) begin
        checks++;
        if (sum !== 9'h100) begin
          errors++;
          $display("FAIL b2b_second: got %h expected 100", sum);
        end
        start = 1'b0;
      end
    end
  endtask

  task automatic test_ignore_midrun;
    for (int n = 0; n < 4; n++) begin
      start_op(8'($urandom), 8'($urandom), 1'b0, 1'b1);
      @(negedge clk);
      checks++;
      if (done !== 1'b0) begin
        errors++;
        $display("FAIL single_done n=%0d: got %b expected 0", n, done);
      end
    end
  endtask

  task automatic test_reset_midrun;
    @(negedge clk);
    start = 1'b1;
    a     = 8'h33;
    b     = 8'h11;
    sub   = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    checks++;
    if (sum !== 9'h004) begin
      errors++;
      $display("FAIL pre_reset_sum: got %h expected 004", sum);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || sum !== 9'h000) begin
      errors++;
      $display("FAIL async_reset: got busy=%b done=%b sum=%h expected 0/0/000",
               busy, done, sum);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || sum !== 9'h000) begin
        errors++;
        $display("FAIL post_reset i=%0d: got busy=%b done=%b sum=%h expected 0/0/000",
                 i, busy, done, sum);
      end
    end
  endtask

  task automatic test_random;
    for (int n = 0; n < 30; n++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      start_op(8'($urandom), 8'($urandom), 1'b0, 1'($urandom));
    end
  endtask

`ifdef SERIAL_ADD_SUB_EN
  task automatic test_sub;
    start_op(8'h10, 8'h20, 1'b1, 1'b0);
    checks++;
    if (sum !== 9'h0F0) begin
      errors++;
      $display("FAIL sub_borrow: got %h expected 0f0", sum);
    end
    start_op(8'h20, 8'h10, 1'b1, 1'b0);
    checks++;
    if (sum !== 9'h110) begin
      errors++;
      $display("FAIL sub_noborrow: got %h expected 110", sum);
    end
    for (int n = 0; n < 20; n++) begin
      start_op(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
    end
  endtask
`endif

  initial begin
    test_reset;
    test_hold;
    test_back_to_back;
    test_ignore_midrun;
    test_reset_midrun;
    test_random;
`ifdef SERIAL_ADD_SUB_EN
    test_sub;
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
